// File: rtl/flex_timer_pkg.sv
// flex_timer_pkg
// Shared types and default widths for the flex_timer block.
//   state_e       : timer state (IDLE / RUN)
//   DEF_CNT_BITS  : default width of the count / load value
//   DEF_PRE_BITS  : default width of the prescale value and prescale counter
package flex_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_CNT_BITS = 8;
  localparam int DEF_PRE_BITS = 4;

endpackage

// File: rtl/flex_prescaler.sv
// flex_prescaler
// Prescale counter for flex_timer. It produces one tick every (prescale+1)
// enabled clocks. The prescale value is latched when clear is asserted, so
// later changes on the prescale input have no effect until the next clear.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clear    in   zero the counter and latch prescale
//   enable   in   count this cycle
//   prescale in   prescale value, latched on clear
//   tick     out  combinational; high in the cycle the counter wraps
module flex_prescaler
  import flex_timer_pkg::*;
#(
  parameter int NUM_PRE_BITS = DEF_PRE_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [NUM_PRE_BITS-1:0] prescale,
  output logic                    tick
);

  logic [NUM_PRE_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_PRE_BITS-1:0] pre_q, pre_d;

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
      pre_d = prescale;
    end else if (enable) begin
      if (cnt_q == pre_q) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/flex_timer.sv
// flex_timer
// Loadable down-counting timer with programmable prescaler. A loaded count
// decrements once every (prescale+1) clocks after start and done pulses for
// one cycle when it reaches zero. Starting with a zero count produces an
// immediate done pulse without entering RUN.
// Optional feature: define FLEX_TIMER_AUTO_RELOAD_EN to reload the count from
// the last loaded value on every terminal tick and stay in RUN (periodic done).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   load       in   capture load_val (ignored while running)
//   load_val   in   value to load
//   prescale   in   tick period minus one, sampled when a start is accepted
//   start      in   begin counting from the current (or just loaded) count
//   abort      in   stop immediately, keep count, return to IDLE
//   count_out  out  current count
//   busy       out  high while running, including the done cycle
//   done       out  one-cycle pulse when the count reaches zero
module flex_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_PRE_BITS = DEF_PRE_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_PRE_BITS-1:0] prescale,
  input  logic                    start,
  input  logic                    abort,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    done
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = 1;

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
`endif

  logic [NUM_CNT_BITS-1:0] start_cnt;
  logic                    start_ok;
  logic                    pre_clear;
  logic                    pre_en;
  logic                    tick;
  logic                    terminal;

  // A simultaneous load supplies the count that start will run from.
  assign start_cnt = load ? load_val : count_q;
  assign start_ok  = (state_q == IDLE) && !abort && start && (start_cnt != '0);
  assign pre_clear = abort || start_ok;
  assign pre_en    = (state_q == RUN) && !abort;

  flex_prescaler #(
    .NUM_PRE_BITS(NUM_PRE_BITS)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear   (pre_clear),
    .enable  (pre_en),
    .prescale(prescale),
    .tick    (tick)
  );

  // Next-state process
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_ok) state_d = RUN;
        RUN: begin
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
          if (terminal && (reload_q == '0)) state_d = IDLE;
`else
          if (terminal) state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output process
  always_comb begin
    count_d  = count_q;
    done_d   = 1'b0;
    terminal = 1'b0;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (!abort) begin
      case (state_q)
        IDLE: begin
          if (load) begin
            count_d = load_val;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
            reload_d = load_val;
`endif
          end
          // Zero-length timer: report completion without running.
          if (start && (start_cnt == '0)) done_d = 1'b1;
        end
        RUN: begin
          if (tick) begin
            // <= rather than == so the count can never wrap below zero.
            if (count_q <= CNT_ONE) begin
              terminal = 1'b1;
              done_d   = 1'b1;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
              count_d  = reload_q;
`else
              count_d  = '0;
`endif
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
    // busy is held through the done cycle of a one-shot run.
    busy_d = (state_d == RUN) || terminal;
  end

  // State and register process
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count_out = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_flex_timer.sv
// tb_flex_timer
// Self-checking bench for flex_timer. A schedule-based reference model
// predicts count/busy/done from the start edge, the start count and the
// latched prescale: count = N - floor(elapsed/(p+1)), done at N*(p+1).
// Build with FLEX_TIMER_AUTO_RELOAD_EN to also exercise periodic reload.
module tb_flex_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] prescale;
  logic       start;
  logic       abort;
  logic [7:0] count_out;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  // reference model
  int         e;        // edge index
  bit         m_run;
  int         m_t0;
  int         m_n;
  int         m_p;
  int         m_cnt;
  int         m_reload;
  logic [9:0] exp_vec;  // {count, busy, done}

  flex_timer dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .prescale (prescale),
    .start    (start),
    .abort    (abort),
    .count_out(count_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance one edge, update the model.
  task automatic step(input logic i_rst, input logic i_load, input logic [7:0] i_lv,
                      input logic [3:0] i_pre, input logic i_start, input logic i_abort);
    int  eff;
    bit  m_done;
    bit  m_term;
    int  cur;
    rst      = i_rst;
    load     = i_load;
    load_val = i_lv;
    prescale = i_pre;
    start    = i_start;
    abort    = i_abort;
    @(posedge clk);
    e++;
    m_done = 1'b0;
    m_term = 1'b0;
    if (i_rst) begin
      m_run = 1'b0; m_cnt = 0; m_reload = 0;
    end else if (i_abort) begin
      if (m_run) m_cnt = m_n - (e - 1 - m_t0) / (m_p + 1);
      m_run = 1'b0;
    end else if (!m_run) begin
      eff = i_load ? int'(i_lv) : m_cnt;
      if (i_load) begin
        m_cnt = i_lv; m_reload = i_lv;
      end
      if (i_start) begin
        if (eff != 0) begin
          m_run = 1'b1; m_t0 = e; m_n = eff; m_p = i_pre;
        end else begin
          m_done = 1'b1;
        end
      end
    end else if ((e - m_t0) == m_n * (m_p + 1)) begin
      m_done = 1'b1;
      m_term = 1'b1;
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
      m_t0 = e; m_n = m_reload;
`else
      m_run = 1'b0; m_cnt = 0;
`endif
    end
    cur = m_run ? (m_n - (e - m_t0) / (m_p + 1)) : m_cnt;
    exp_vec = {cur[7:0], (m_run | m_term), m_done};
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 8'd0, 4'd0, 0, 0);
    step(1, 0, 8'd0, 4'd0, 0, 0);
    checks++;
    if ({count_out, busy, done} !== 10'd0) begin
      errors++;
      $display("FAIL reset: got cnt=%0d busy=%0b done=%0b, want all 0", count_out, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'd0, 4'd0, 0, 0);
      checks++;
      if ({count_out, busy, done} !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle: got %h want %h", {count_out, busy, done}, exp_vec);
      end
    end
  endtask

  task automatic test_one_shot();
    int pulses;
    logic [7:0] want_cnt [0:7];
    want_cnt = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
    pulses = 0;
    step(0, 1, 8'd3, 4'd1, 1, 0);                  // E0
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(0, 0, 8'd0, 4'd1, 0, 0);     // edge E0+k
      checks++;
      if ({count_out, busy, done} !== exp_vec || count_out !== want_cnt[k]) begin
        errors++;
        $display("FAIL one_shot E0+%0d: got %h want %h (cnt %0d)", k,
                 {count_out, busy, done}, exp_vec, want_cnt[k]);
      end
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_pulse: got pulses=%0d busy=%0b want 1/0", pulses, busy);
    end
  endtask

  task automatic test_zero_and_ignored();
    step(1, 0, 8'd0, 4'd0, 0, 0);
    step(0, 0, 8'd0, 4'd2, 1, 0);                  // start with zero count
    checks++;
    if ({count_out, busy, done} !== 10'b00000000_0_1) begin
      errors++;
      $display("FAIL zero_len: got %h want %h", {count_out, busy, done}, 10'b00000000_0_1);
    end
    step(0, 0, 8'd0, 4'd2, 0, 0);
    checks++;
    if ({count_out, busy, done} !== exp_vec || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: got %h want %h", {count_out, busy, done}, exp_vec);
    end
    step(0, 1, 8'd4, 4'd0, 1, 0);
    step(0, 1, 8'd9, 4'd0, 0, 0);                  // load mid-RUN
    checks++;
    if ({count_out, busy, done} !== exp_vec || count_out !== 8'd3) begin
      errors++;
      $display("FAIL load_in_run: got %h want %h", {count_out, busy, done}, exp_vec);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'd0, 4'd0, (i == 1), 0);         // start mid-RUN ignored
      checks++;
      if ({count_out, busy, done} !== exp_vec) begin
        errors++;
        $display("FAIL ignored_run %0d: got %h want %h", i, {count_out, busy, done}, exp_vec);
      end
    end
  endtask

  task automatic test_abort_resume();
    step(0, 1, 8'd5, 4'd0, 1, 0);
    step(0, 0, 8'd0, 4'd0, 0, 0);
    step(0, 0, 8'd0, 4'd0, 0, 0);
    step(0, 1, 8'd7, 4'd0, 0, 1);                  // abort beats load
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({count_out, busy, done} !== exp_vec || count_out !== 8'd3 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_hold %0d: got %h want %h", i, {count_out, busy, done}, exp_vec);
      end
      step(0, 0, 8'd0, 4'd0, 0, 0);
    end
    step(0, 0, 8'd0, 4'd0, 1, 0);                  // resume, edge E1
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 8'd0, 4'd0, 0, 0);
      checks++;
      if ({count_out, busy, done} !== exp_vec || done !== (k == 3)) begin
        errors++;
        $display("FAIL resume E1+%0d: got %h want %h", k, {count_out, busy, done}, exp_vec);
      end
    end
  endtask

  task automatic test_prescale_latch();
    step(0, 1, 8'd6, 4'd1, 1, 0);                  // E0, p=1
    for (int k = 1; k <= 13; k++) begin
      step(0, 0, 8'd0, 4'd7, 0, 0);                // prescale input changed
      checks++;
      if ({count_out, busy, done} !== exp_vec) begin
        errors++;
        $display("FAIL prescale_latch E0+%0d: got %h want %h", k, {count_out, busy, done}, exp_vec);
      end
    end
  endtask

`ifdef FLEX_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int pulses;
    pulses = 0;
    step(0, 1, 8'd2, 4'd2, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 8'd0, 4'd2, 0, 0);
      checks++;
      if ({count_out, busy, done} !== exp_vec || busy !== 1'b1 || done !== (k % 6 == 0)) begin
        errors++;
        $display("FAIL auto_reload E0+%0d: got %h want %h", k, {count_out, busy, done}, exp_vec);
      end
      if (done) pulses++;
    end
    step(0, 0, 8'd0, 4'd2, 0, 1);
    step(0, 0, 8'd0, 4'd2, 0, 0);
    checks++;
    if ({count_out, busy, done} !== exp_vec || busy !== 1'b0 || pulses !== 3) begin
      errors++;
      $display("FAIL auto_reload_abort: got %h pulses=%0d want %h pulses=3",
               {count_out, busy, done}, pulses, exp_vec);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 15), 8'($urandom_range(12)),
           4'($urandom_range(3)), ($urandom_range(99) < 15), ($urandom_range(99) < 4));
      checks++;
      if ({count_out, busy, done} !== exp_vec) begin
        errors++;
        $display("FAIL random %0d: got %h want %h", i, {count_out, busy, done}, exp_vec);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; e = 0;
    m_run = 1'b0; m_t0 = 0; m_n = 0; m_p = 0; m_cnt = 0; m_reload = 0;
    exp_vec = '0;
    rst = 1'b1; load = 1'b0; load_val = '0; prescale = '0; start = 1'b0; abort = 1'b0;
    test_reset();
    test_one_shot();
    test_zero_and_ignored();
    test_abort_resume();
    step(1, 0, 8'd0, 4'd0, 0, 0);
    test_prescale_latch();
`ifdef FLEX_TIMER_AUTO_RELOAD_EN
    step(1, 0, 8'd0, 4'd0, 0, 0);
    test_auto_reload();
`endif
    step(1, 0, 8'd0, 4'd0, 0, 0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
